// File: rtl/bullet_motion_collider.sv
// Bullet motion and collision tracker: spawns a bullet at the shooter's leading edge, steps it once
// per frame tick, and reports screen-edge, wall-tile or target-tank hits to the bullet control FSM.
module bullet_motion_collider #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned TILE_SHIFT   = 4,
  parameter int unsigned TANK_SIZE    = 32,
  parameter int unsigned BULLET_SIZE  = 4,
  parameter int unsigned BULLET_SPEED = 4
) (
  input  logic        fsm_clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        drawbulletsignal,
  input  logic [9:0]  shooter_x,
  input  logic [9:0]  shooter_y,
  input  logic [1:0]  shooter_dir,
  input  logic [9:0]  target_x,
  input  logic [9:0]  target_y,
  output logic [10:0] wall_addr,
  input  logic        wall_data,
  output logic [9:0]  bullet_x,
  output logic [9:0]  bullet_y,
  output logic        bullet_active,
  output logic        bulletwallcollisionsignal,
  output logic        bullettankcollisionsignal
);

  localparam logic [10:0] HalfW    = 11'(TANK_SIZE / 2 - BULLET_SIZE / 2);
  localparam logic [10:0] TankW    = 11'(TANK_SIZE);
  localparam logic [10:0] BulW     = 11'(BULLET_SIZE);
  localparam logic [10:0] HalfBulW = 11'(BULLET_SIZE / 2);
  localparam logic [10:0] SpdW     = 11'(BULLET_SPEED);
  localparam logic [10:0] ScrW     = 11'(SCREEN_W);
  localparam logic [10:0] ScrH     = 11'(SCREEN_H);
  localparam logic [10:0] MapW     = 11'(SCREEN_W >> TILE_SHIFT);

  typedef enum logic [2:0] {
    StIdle, StSpawn, StWaitTick, StMove, StWallRd, StWallChk, StHit
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        kind_tank_q, kind_tank_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        draw_q;
  logic        active_q, wall_hit_q, tank_hit_q;

  logic [10:0] sp_x, sp_y, mv_x, mv_y, tx, ty, cx, cy;
  logic        sp_under, sp_oob, mv_under, mv_oob, hit_tank;

  // Spawn position at the tank's leading edge, centred on the perpendicular axis.
  always_comb begin
    sp_x     = {1'b0, shooter_x};
    sp_y     = {1'b0, shooter_y};
    sp_under = 1'b0;
    unique case (shooter_dir)
      2'd0: begin
        sp_x     = sp_x + HalfW;
        sp_under = sp_y < BulW;
        sp_y     = sp_y - BulW;
      end
      2'd1: begin
        sp_x = sp_x + TankW;
        sp_y = sp_y + HalfW;
      end
      2'd2: begin
        sp_x = sp_x + HalfW;
        sp_y = sp_y + TankW;
      end
      default: begin
        sp_under = sp_x < BulW;
        sp_x     = sp_x - BulW;
        sp_y     = sp_y + HalfW;
      end
    endcase
    sp_oob = sp_under || (sp_x + BulW > ScrW) || (sp_y + BulW > ScrH);
  end

  always_comb begin
    mv_x     = {1'b0, x_q};
    mv_y     = {1'b0, y_q};
    mv_under = 1'b0;
    unique case (dir_q)
      2'd0: begin
        mv_under = mv_y < SpdW;
        mv_y     = mv_y - SpdW;
      end
      2'd1:    mv_x = mv_x + SpdW;
      2'd2:    mv_y = mv_y + SpdW;
      default: begin
        mv_under = mv_x < SpdW;
        mv_x     = mv_x - SpdW;
      end
    endcase
    mv_oob   = mv_under || (mv_x + BulW > ScrW) || (mv_y + BulW > ScrH);
    tx       = {1'b0, target_x};
    ty       = {1'b0, target_y};
    hit_tank = (mv_x < tx + TankW) && (mv_x + BulW > tx) &&
               (mv_y < ty + TankW) && (mv_y + BulW > ty);
  end

  assign cx        = {1'b0, x_q} + HalfBulW;
  assign cy        = {1'b0, y_q} + HalfBulW;
  assign wall_addr = (cy >> TILE_SHIFT) * MapW + (cx >> TILE_SHIFT);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    kind_tank_d = kind_tank_q;
    x_d         = x_q;
    y_d         = y_q;
    unique case (state_q)
      StIdle:     if (drawbulletsignal && !draw_q) state_d = StSpawn;
      StSpawn: begin
        dir_d = shooter_dir;
        if (sp_oob) begin
          state_d     = StHit;
          kind_tank_d = 1'b0;
        end else begin
          x_d     = sp_x[9:0];
          y_d     = sp_y[9:0];
          state_d = StWallRd;
        end
      end
      StWaitTick: if (frame_tick) state_d = StMove;
      StMove: begin
        if (mv_oob) begin
          state_d     = StHit;
          kind_tank_d = 1'b0;
        end else begin
          x_d = mv_x[9:0];
          y_d = mv_y[9:0];
          if (hit_tank) begin
            state_d     = StHit;
            kind_tank_d = 1'b1;
          end else begin
            state_d = StWallRd;
          end
        end
      end
      StWallRd:   state_d = StWallChk;
      StWallChk: begin
        if (wall_data) begin
          state_d     = StHit;
          kind_tank_d = 1'b0;
        end else begin
          state_d = StWaitTick;
        end
      end
      StHit:      if (!drawbulletsignal) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    // Abort: the FSM withdrew the bullet before any collision was reported.
    if (!drawbulletsignal && state_q != StIdle && state_q != StHit) state_d = StIdle;
    if (state_d == StIdle) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge fsm_clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_q       <= '0;
      kind_tank_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      draw_q      <= 1'b0;
      active_q    <= 1'b0;
      wall_hit_q  <= 1'b0;
      tank_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      kind_tank_q <= kind_tank_d;
      x_q         <= x_d;
      y_q         <= y_d;
      draw_q      <= drawbulletsignal;
      active_q    <= (state_d != StIdle);
      wall_hit_q  <= (state_d == StHit) && !kind_tank_d;
      tank_hit_q  <= (state_d == StHit) && kind_tank_d;
    end
  end

  assign bullet_x                  = x_q;
  assign bullet_y                  = y_q;
  assign bullet_active             = active_q;
  assign bulletwallcollisionsignal = wall_hit_q;
  assign bullettankcollisionsignal = tank_hit_q;

endmodule

// File: tb/tb_bullet_motion_collider.sv
// Directed bench for bullet_motion_collider: table of whole-flight scenarios plus
// hand-timed sequences for latency, abort, ignored ticks and asynchronous reset.
module tb_bullet_motion_collider;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        draw;
  logic [9:0]  sx, sy, tx, ty;
  logic [1:0]  dir;
  logic [10:0] wall_addr;
  logic        wall_data;
  logic [9:0]  bx, by;
  logic        active, wall_hit, tank_hit;

  logic        wall_map [0:2047];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // Tile ROM with one cycle of read latency.
  always @(posedge clk) wall_data <= wall_map[wall_addr];

  bullet_motion_collider dut (
    .fsm_clock                 (clk),
    .reset                     (reset),
    .frame_tick                (frame_tick),
    .drawbulletsignal          (draw),
    .shooter_x                 (sx),
    .shooter_y                 (sy),
    .shooter_dir               (dir),
    .target_x                  (tx),
    .target_y                  (ty),
    .wall_addr                 (wall_addr),
    .wall_data                 (wall_data),
    .bullet_x                  (bx),
    .bullet_y                  (by),
    .bullet_active             (active),
    .bulletwallcollisionsignal (wall_hit),
    .bullettankcollisionsignal (tank_hit)
  );

  typedef struct {
    logic [9:0] sx, sy;
    logic [1:0] dir;
    logic [9:0] tx, ty;
    int         solid;
    int         nticks;
    int         ex, ey;
    int         eact, ewall, etank;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map(input int solid);
    for (int i = 0; i < 2048; i++) wall_map[i] = 1'b0;
    if (solid >= 0) wall_map[solid] = 1'b1;
  endtask

  // Fire and advance until the spawn wall check has completed.
  task automatic fire(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    sx = x; sy = y; dir = d;
    draw = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic release_bullet();
    draw = 1'b0;
    step();
    step();
  endtask

  initial begin
    vecs[0] = '{10'd100, 10'd200, 2'd0, 10'd500, 10'd400, -1,  2, 114, 188, 1, 0, 0};
    vecs[1] = '{10'd64,  10'd192, 2'd1, 10'd500, 10'd400, 528, 8, 128, 206, 1, 1, 0};
    vecs[2] = '{10'd100, 10'd200, 2'd1, 10'd140, 10'd190, 537, 2, 140, 214, 1, 0, 1};
    vecs[3] = '{10'd2,   10'd100, 2'd3, 10'd500, 10'd400, -1,  0, 0,   0,   1, 1, 0};
    vecs[4] = '{10'd600, 10'd100, 2'd1, 10'd0,   10'd400, -1,  2, 636, 114, 1, 1, 0};
    vecs[5] = '{10'd300, 10'd440, 2'd2, 10'd0,   10'd0,   -1,  2, 314, 476, 1, 1, 0};
    vecs[6] = '{10'd200, 10'd8,   2'd0, 10'd400, 10'd400, -1,  2, 214, 0,   1, 1, 0};
    vecs[7] = '{10'd600, 10'd100, 2'd1, 10'd641, 10'd100, -1,  2, 636, 114, 1, 1, 0};

    reset = 1'b1; draw = 1'b0; frame_tick = 1'b0;
    sx = '0; sy = '0; dir = '0; tx = 10'd500; ty = 10'd400;
    clear_map(-1);
    step(); step();
    chk("reset_active", int'(active), 0);
    chk("reset_x", int'(bx), 0);
    chk("reset_wall_addr", int'(wall_addr), 0);
    chk("reset_coll", int'({wall_hit, tank_hit}), 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      clear_map(vecs[v].solid);
      tx = vecs[v].tx; ty = vecs[v].ty;
      fire(vecs[v].sx, vecs[v].sy, vecs[v].dir);
      for (int t = 0; t < vecs[v].nticks; t++) do_tick();
      chk($sformatf("vec%0d_x", v), int'(bx), vecs[v].ex);
      chk($sformatf("vec%0d_y", v), int'(by), vecs[v].ey);
      chk($sformatf("vec%0d_active", v), int'(active), vecs[v].eact);
      chk($sformatf("vec%0d_wall", v), int'(wall_hit), vecs[v].ewall);
      chk($sformatf("vec%0d_tank", v), int'(tank_hit), vecs[v].etank);
      release_bullet();
      chk($sformatf("vec%0d_released", v), int'({active, wall_hit, tank_hit}), 0);
    end

    // Fire latency and per-tick position latency, moving up.
    clear_map(-1); tx = 10'd500; ty = 10'd400;
    sx = 10'd100; sy = 10'd200; dir = 2'd0; draw = 1'b1;
    step(); step();
    chk("up_spawn_x", int'(bx), 114);
    chk("up_spawn_y", int'(by), 196);
    chk("up_spawn_active", int'(active), 1);
    // Tick while in WALL_RD must be dropped.
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); step(); step();
    chk("up_ignored_tick_y", int'(by), 196);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("up_tick1_y", int'(by), 192);
    step(); step();
    do_tick();
    chk("up_tick2_y", int'(by), 188);

    // Abort from WAIT_TICK, then re-fire.
    draw = 1'b0; step();
    chk("abort_active", int'(active), 0);
    chk("abort_pos", int'({bx, by}), 0);
    chk("abort_coll", int'({wall_hit, tank_hit}), 0);
    draw = 1'b1; step(); step();
    chk("refire_y", int'(by), 196);
    chk("refire_active", int'(active), 1);
    release_bullet();

    // Spawn underflow: hit visible two cycles after fire, held until draw drops.
    sx = 10'd2; sy = 10'd100; dir = 2'd3; draw = 1'b1;
    step();
    chk("edge_early", int'(wall_hit), 0);
    step();
    chk("edge_wall", int'(wall_hit), 1);
    chk("edge_tank", int'(tank_hit), 0);
    step(); step(); step();
    chk("edge_hold", int'(wall_hit), 1);
    draw = 1'b0; step();
    chk("edge_clear", int'(wall_hit), 0);
    step();

    // Wall tile hit lands four cycles after the tick, not three.
    clear_map(528);
    fire(10'd64, 10'd192, 2'd1);
    chk("tile_spawn_x", int'(bx), 96);
    for (int t = 0; t < 7; t++) do_tick();
    chk("tile_x7", int'(bx), 124);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("tile_x8", int'(bx), 128);
    step();
    chk("tile_wall_t3", int'(wall_hit), 0);
    step();
    chk("tile_wall_t4", int'(wall_hit), 1);
    release_bullet();

    // Tank hit visible two cycles after the second tick.
    clear_map(537); tx = 10'd140; ty = 10'd190;
    fire(10'd100, 10'd200, 2'd1);
    chk("tank_spawn_x", int'(bx), 132);
    chk("tank_spawn_y", int'(by), 214);
    do_tick();
    chk("tank_x1", int'(bx), 136);
    chk("tank_none1", int'(tank_hit), 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("tank_hit_t2", int'(tank_hit), 1);
    chk("tank_wall_t2", int'(wall_hit), 0);
    step(); step();
    chk("tank_wall_later", int'(wall_hit), 0);
    release_bullet();

    // Asynchronous reset mid-flight at (114,150).
    clear_map(-1); tx = 10'd500; ty = 10'd400;
    sx = 10'd100; sy = 10'd154; dir = 2'd0; draw = 1'b1;
    step(); step();
    chk("rst_pre_pos", int'({bx, by}), int'({10'd114, 10'd150}));
    #2 reset = 1'b1;
    #1;
    chk("rst_async_pos", int'({bx, by}), 0);
    chk("rst_async_active", int'(active), 0);
    chk("rst_async_addr", int'(wall_addr), 0);
    draw = 1'b0;
    step();
    reset = 1'b0;
    step(); step();
    chk("rst_idle_active", int'(active), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
